// File: rtl/ysyx_24110026_mem_responder.sv
// Purpose: single-port 32-bit word memory answering the core's valid/ready memory requests (read or byte-masked write).
// Latency: resp_valid rises exactly LATENCY cycles after the accept edge; one transaction in flight at a time.
// Backpressure: the response is held (valid, rdata and err all stable) until resp_ready; req_ready is low outside IDLE.
//
// Ports:
//   clk, rst                    clock; synchronous active-low reset (memory contents survive reset)
//   req_valid/req_ready         request handshake; req_wen, req_addr, req_wdata, req_wmask are the request fields
//   resp_valid/resp_ready       response handshake; resp_rdata is the old word contents, resp_err flags out-of-range
module ysyx_24110026_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             wen_q;
    logic             err_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;

    logic [31:0]      mem [DEPTH_WORDS];

    // Address decode of the incoming request. The subtraction wraps for
    // addresses below BASE_ADDR, so that case is flagged explicitly.
    logic [31:0]      off;
    logic             req_err;
    logic [IDX_W-1:0] req_idx;

    assign off     = req_addr - BASE_ADDR;
    assign req_err = (req_addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH_WORDS));
    assign req_idx = off[IDX_W+1:2];

    // The accept edge only registers the request, so WAIT always lasts at
    // least one cycle; cnt counts the remaining cycles so that the RESP
    // entry edge lands exactly LATENCY edges after the accept edge.
    logic enter_resp;
    assign enter_resp = (state == WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            cnt        <= 4'd0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            wmask_q    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        wen_q     <= req_wen;
                        err_q     <= req_err;
                        idx_q     <= req_idx;
                        wdata_q   <= req_wdata;
                        wmask_q   <= req_wmask;
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        // Old contents are returned; the write (if any)
                        // lands on this same edge in the array block below.
                        resp_valid <= 1'b1;
                        resp_err   <= err_q;
                        resp_rdata <= err_q ? 32'd0 : mem[idx_q];
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-masked write commits only on the RESP entry edge, so a reset
    // arriving before that edge drops the write entirely.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && wen_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24110026_mem_responder.sv
// Bench for ysyx_24110026_mem_responder: two instances (LATENCY 1 and 3) sharing clock and reset,
// driven by directed scenarios plus randomized traffic checked against a word-array reference model.
// Blocks on DUT events are bounded; the run ends with a single summary line.
module tb_ysyx_24110026_mem_responder;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_wen    [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_wmask  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int checks;
    int errors;

    // Reference model: plain word array per instance plus a "contents known" flag,
    // since the DUT memory is never initialised.
    logic [31:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];

    ysyx_24110026_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h8000_0000), .LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    ysyx_24110026_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Returns the expected response for a request and applies its effect to the model.
    function automatic void model_apply(input int d, input bit wen, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] wmask,
                                        output logic [31:0] er, output bit ee, output bit ek);
        longint a;
        int     idx;
        a  = addr;
        ee = (a < 64'h8000_0000) || (a >= 64'h8000_0000 + 4 * DEPTH);
        er = 32'd0;
        ek = 1'b1;
        if (ee) return;
        idx = int'((a - 64'h8000_0000) / 4);
        er  = mdl[d][idx];
        ek  = known[d][idx];
        if (wen) begin
            for (int i = 0; i < 4; i++)
                if (wmask[i]) mdl[d][idx][8*i +: 8] = wdata[8*i +: 8];
            if (wmask == 4'hF) known[d][idx] = 1'b1;
        end
    endfunction

    // Drives one transaction on instance d, checking latency, req_ready during the
    // wait, response stability under hold cycles of backpressure, and the return to IDLE.
    task automatic txn(input int d, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int hold,
                       output logic [31:0] rdata, output logic err);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (req_ready[d] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout dut%0d got %b want 1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wen[d]   = 1'b0;
        lat = 0;
        while (resp_valid[d] !== 1'b1 && lat < 40) begin
            checks++;
            if (req_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_wait dut%0d got %b want 0", d, req_ready[d]);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== lat_of(d)) begin
            errors++;
            $display("FAIL latency dut%0d got %0d want %0d", d, lat, lat_of(d));
        end
        rdata = resp_rdata[d];
        err   = resp_err[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== rdata || resp_err[d] !== err || req_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable dut%0d cycle %0d got v=%b d=%h e=%b r=%b want v=1 d=%h e=%b r=0",
                         d, h, resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d], rdata, err);
            end
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready[d] = 1'b0;
        checks++;
        if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake dut%0d got v=%b r=%b want v=0 r=1", d, resp_valid[d], req_ready[d]);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_wmask[d] = 4'd0; resp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d got r=%b v=%b d=%h e=%b want r=0 v=0 d=0 e=0",
                         d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_ready dut%0d got r=%b v=%b want r=1 v=0", d, req_ready[d], resp_valid[d]);
            end
        end
    endtask

    task automatic test_basic(input int d);
        logic [31:0] r, er;
        logic        e;
        bit          ee, ek;
        model_apply(d, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, er, ee, ek);
        txn(d, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, r, e);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL basic_write_err dut%0d got %b want 0", d, e); end
        model_apply(d, 1'b0, 32'h8000_0010, 32'd0, 4'h0, er, ee, ek);
        txn(d, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, r, e);
        checks++;
        if (r !== er || e !== ee) begin
            errors++;
            $display("FAIL basic_read dut%0d got %h/%b want %h/%b", d, r, e, er, ee);
        end
    endtask

    task automatic test_byte_mask;
        logic [31:0] r, er;
        logic        e;
        bit          ee, ek;
        model_apply(0, 1'b1, 32'h8000_0040, 32'h1122_3344, 4'hF, er, ee, ek);
        txn(0, 1'b1, 32'h8000_0040, 32'h1122_3344, 4'hF, 0, r, e);
        model_apply(0, 1'b1, 32'h8000_0040, 32'hAABB_CCDD, 4'b0101, er, ee, ek);
        txn(0, 1'b1, 32'h8000_0040, 32'hAABB_CCDD, 4'b0101, 0, r, e);
        checks++;
        if (r !== 32'h1122_3344) begin errors++; $display("FAIL mask_write_old got %h want 11223344", r); end
        txn(0, 1'b0, 32'h8000_0042, 32'd0, 4'h0, 0, r, e);
        checks++;
        if (r !== 32'h11BB_33DD || e !== 1'b0) begin
            errors++;
            $display("FAIL mask_read got %h/%b want 11bb33dd/0", r, e);
        end
        model_apply(0, 1'b0, 32'h8000_0040, 32'd0, 4'h0, er, ee, ek);
    endtask

    task automatic test_range;
        logic [31:0] r, er;
        logic        e;
        bit          ee, ek;
        logic [31:0] bad  [4];
        logic [31:0] edge_a [2];
        bad[0] = 32'h7FFF_FFFC; bad[1] = 32'h8000_1000; bad[2] = 32'h0000_0000; bad[3] = 32'hFFFF_FFFC;
        edge_a[0] = 32'h8000_0000; edge_a[1] = 32'h8000_0FFC;
        for (int k = 0; k < 2; k++) begin
            model_apply(0, 1'b1, edge_a[k], 32'h5A5A_0000 + k, 4'hF, er, ee, ek);
            txn(0, 1'b1, edge_a[k], 32'h5A5A_0000 + k, 4'hF, 0, r, e);
            checks++;
            if (e !== 1'b0) begin errors++; $display("FAIL edge_in_range %h got err %b want 0", edge_a[k], e); end
        end
        for (int k = 0; k < 4; k++) begin
            txn(0, k[0], bad[k], 32'hFFFF_FFFF, 4'hF, 0, r, e);
            checks++;
            if (r !== 32'd0 || e !== 1'b1) begin
                errors++;
                $display("FAIL range_err %h got %h/%b want 00000000/1", bad[k], r, e);
            end
        end
        for (int k = 0; k < 2; k++) begin
            model_apply(0, 1'b0, edge_a[k], 32'd0, 4'h0, er, ee, ek);
            txn(0, 1'b0, edge_a[k], 32'd0, 4'h0, 0, r, e);
            checks++;
            if (r !== er || e !== 1'b0) begin
                errors++;
                $display("FAIL range_untouched %h got %h/%b want %h/0", edge_a[k], r, e, er);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] r, er;
        logic        e;
        bit          ee, ek;
        model_apply(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, er, ee, ek);
        txn(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 5, r, e);
        checks++;
        if (r !== er || e !== ee) begin
            errors++;
            $display("FAIL backpressure_data got %h/%b want %h/%b", r, e, er, ee);
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] r, er;
        logic        e;
        bit          ee, ek;
        int          guard;
        model_apply(1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, er, ee, ek);
        txn(1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, 0, r, e);
        guard = 0;
        @(negedge clk);
        while (req_ready[1] !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
        req_wdata[1] = 32'hCAFE_F00D; req_wmask[1] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0; req_wen[1] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rst = 1'b1;
            @(negedge clk);
            checks++;
            if (resp_valid[1] !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop cycle %0d got resp_valid %b want 0", k, resp_valid[1]);
            end
        end
        model_apply(1, 1'b0, 32'h8000_0020, 32'd0, 4'h0, er, ee, ek);
        txn(1, 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, r, e);
        checks++;
        if (r !== 32'h1234_5678 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_keeps_old got %h/%b want 12345678/0", r, e);
        end
    endtask

    task automatic test_random;
        logic [31:0] pool [10];
        logic [31:0] r, er, a, wd;
        logic [3:0]  wm;
        logic        e;
        bit          ee, ek, w;
        pool[0] = 32'h8000_0100; pool[1] = 32'h8000_0104; pool[2] = 32'h8000_0108;
        pool[3] = 32'h8000_0200; pool[4] = 32'h8000_0FFC; pool[5] = 32'h8000_0000;
        pool[6] = 32'h7FFF_FFFC; pool[7] = 32'h8000_1000; pool[8] = 32'h8000_1004; pool[9] = 32'h0000_0100;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 6; k++) begin
                wd = $urandom;
                model_apply(d, 1'b1, pool[k], wd, 4'hF, er, ee, ek);
                txn(d, 1'b1, pool[k], wd, 4'hF, 0, r, e);
            end
            for (int k = 0; k < 50; k++) begin
                a  = pool[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
                w  = 1'($urandom_range(0, 1));
                wd = $urandom;
                wm = 4'($urandom_range(0, 15));
                model_apply(d, w, a, wd, wm, er, ee, ek);
                txn(d, w, a, wd, wm, $urandom_range(0, 2), r, e);
                checks++;
                if (e !== ee || (ek && r !== er)) begin
                    errors++;
                    $display("FAIL random dut%0d #%0d addr %h wen %b got %h/%b want %h/%b",
                             d, k, a, w, r, e, er, ee);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) begin
                mdl[d][i]   = 32'd0;
                known[d][i] = 1'b0;
            end
        test_reset();
        test_basic(0);
        test_basic(1);
        test_byte_mask();
        test_range();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
